// File: rtl/egg_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : egg_timer_pkg
// Description : Shared types, constants and BCD helpers for multi_egg_timer.
// Revision    : 1.0 - initial release
// ============================================================================
package egg_timer_pkg;

  localparam int         TIME_W   = 14;
  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [2:0] TENS_MAX = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOADED = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSED = 3'd3,
    ST_ALARM  = 3'd4
  } ch_state_e;

  typedef struct packed {
    logic [2:0] m_tens;
    logic [3:0] m_ones;
    logic [2:0] s_tens;
    logic [3:0] s_ones;
  } bcd_time_t;

  localparam bcd_time_t BCD_ZERO = bcd_time_t'(14'd0);
  localparam bcd_time_t BCD_ONE  = bcd_time_t'(14'd1);

  function automatic logic bcd_valid(input bcd_time_t t);
    return (t.m_ones <= ONES_MAX) && (t.s_tens <= TENS_MAX) && (t.s_ones <= ONES_MAX);
  endfunction

  // One-second decrement with borrow ripple across the four digits.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.s_ones != 4'd0) begin
      r.s_ones = t.s_ones - 4'd1;
    end else begin
      r.s_ones = ONES_MAX;
      if (t.s_tens != 3'd0) begin
        r.s_tens = t.s_tens - 3'd1;
      end else begin
        r.s_tens = TENS_MAX;
        if (t.m_ones != 4'd0) begin
          r.m_ones = t.m_ones - 4'd1;
        end else begin
          r.m_ones = ONES_MAX;
          r.m_tens = t.m_tens - 3'd1;
        end
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/egg_timer_channel.sv
`default_nettype none
// ============================================================================
// Module      : egg_timer_channel
// Description : One timer channel: control FSM plus BCD MM:SS downcounter.
//               EGG_TIMER_AUTO_RELOAD_EN: reload last valid load at 00:00.
// Revision    : 1.0 - initial release
// ============================================================================
module egg_timer_channel
  import egg_timer_pkg::*;
#(
  parameter int ALARM_SEC = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_i,
  input  logic              load_en_i,
  input  logic [TIME_W-1:0] load_time_i,
  input  logic              start_i,
  input  logic              pause_i,
  input  logic              clear_i,
  output logic [TIME_W-1:0] time_o,
  output logic              running_o,
  output logic              done_o,
  output logic              alarm_o,
  output logic              load_err_o
);

  localparam int           AW         = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);

  ch_state_e     state_q, state_d;
  bcd_time_t     time_q, time_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic          done_q, done_d;
  logic          lerr_q, lerr_d;
  bcd_time_t     w_load;
  logic          w_terminal;
`ifdef EGG_TIMER_AUTO_RELOAD_EN
  bcd_time_t     last_q, last_d;
`endif

  assign w_load     = bcd_time_t'(load_time_i);
  assign w_terminal = (time_q == BCD_ONE) || (time_q == BCD_ZERO);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      time_q  <= BCD_ZERO;
      acnt_q  <= '0;
      done_q  <= 1'b0;
      lerr_q  <= 1'b0;
`ifdef EGG_TIMER_AUTO_RELOAD_EN
      last_q  <= BCD_ZERO;
`endif
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      acnt_q  <= acnt_d;
      done_q  <= done_d;
      lerr_q  <= lerr_d;
`ifdef EGG_TIMER_AUTO_RELOAD_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    acnt_d  = acnt_q;
    done_d  = 1'b0;
    lerr_d  = 1'b0;
`ifdef EGG_TIMER_AUTO_RELOAD_EN
    last_d  = last_q;
`endif
    if (clear_i) begin
      state_d = ST_IDLE;
      time_d  = BCD_ZERO;
      acnt_d  = '0;
    end else if (load_en_i && (state_q == ST_IDLE || state_q == ST_LOADED)) begin
      // A rejected load still consumes the cycle, so a same-cycle start is dropped.
      if (bcd_valid(w_load)) begin
        state_d = ST_LOADED;
        time_d  = w_load;
`ifdef EGG_TIMER_AUTO_RELOAD_EN
        last_d  = w_load;
`endif
      end else begin
        lerr_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_LOADED: begin
          if (start_i && (time_q != BCD_ZERO)) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (tick_i) begin
            if (w_terminal) begin
              done_d = 1'b1;
`ifdef EGG_TIMER_AUTO_RELOAD_EN
              time_d = last_q;
`else
              time_d  = BCD_ZERO;
              state_d = ST_ALARM;
              acnt_d  = '0;
`endif
            end else begin
              time_d = bcd_dec(time_q);
            end
          end
          // The terminal tick wins over pause; otherwise the decremented value is kept.
          if (pause_i && (state_d == ST_RUN)) state_d = ST_PAUSED;
        end
        ST_PAUSED: begin
          if (start_i) state_d = ST_RUN;
        end
        ST_ALARM: begin
          if (tick_i) begin
            if (acnt_q == ALARM_LAST) begin
              state_d = ST_IDLE;
              time_d  = BCD_ZERO;
              acnt_d  = '0;
            end else begin
              acnt_d = acnt_q + AW'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          time_d  = BCD_ZERO;
        end
      endcase
    end
  end

  always_comb begin
    time_o     = time_q;
    running_o  = (state_q == ST_RUN);
    alarm_o    = (state_q == ST_ALARM);
    done_o     = done_q;
    load_err_o = lerr_q;
  end

endmodule
`default_nettype wire

// File: rtl/multi_egg_timer.sv
`default_nettype none
// ============================================================================
// Module      : multi_egg_timer
// Description : NUM_CH independent MM:SS egg timers sharing one-second tick.
//               EGG_TIMER_AUTO_RELOAD_EN selects auto-reload at 00:00.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_egg_timer
  import egg_timer_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int TICK_DIV  = 50000000,
  parameter int ALARM_SEC = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        load_en,
  input  logic [TIME_W-1:0]        load_time,
  input  logic [NUM_CH-1:0]        start,
  input  logic [NUM_CH-1:0]        pause,
  input  logic [NUM_CH-1:0]        clear,
  output logic [TIME_W*NUM_CH-1:0] time_out,
  output logic [NUM_CH-1:0]        running,
  output logic [NUM_CH-1:0]        done,
  output logic [NUM_CH-1:0]        alarm,
  output logic [NUM_CH-1:0]        load_err
);

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  assign tick    = (presc_q == PRE_LAST);
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  always_ff @(posedge clk) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      egg_timer_channel #(
        .ALARM_SEC (ALARM_SEC)
      ) u_channel (
        .clk         (clk),
        .reset       (reset),
        .tick_i      (tick),
        .load_en_i   (load_en[i]),
        .load_time_i (load_time),
        .start_i     (start[i]),
        .pause_i     (pause[i]),
        .clear_i     (clear[i]),
        .time_o      (time_out[TIME_W*i +: TIME_W]),
        .running_o   (running[i]),
        .done_o      (done[i]),
        .alarm_o     (alarm[i]),
        .load_err_o  (load_err[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/multi_egg_timer.md
MULTI_EGG_TIMER -- requirements
Module: multi_egg_timer

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent timer channels, legal range 1..8.
REQ-002 Parameter TICK_DIV, default 50000000: clk cycles per one-second tick, minimum 2.
REQ-003 Parameter ALARM_SEC, default 10: seconds the alarm stays asserted before the channel self-clears to IDLE.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 load_en  in  NUM_CH  per-channel load strobe, single cycle.
REQ-007 load_time  in  14  load value shared by all channels, MM:SS BCD {m_tens[2:0], m_ones[3:0], s_tens[2:0], s_ones[3:0]}.
REQ-008 start  in  NUM_CH  per-channel start/resume strobe.
REQ-009 pause  in  NUM_CH  per-channel pause strobe.
REQ-010 clear  in  NUM_CH  per-channel abort/acknowledge strobe.
REQ-011 time_out  out  14*NUM_CH  current BCD time, channel i at bits [14*i+13:14*i].
REQ-012 running  out  NUM_CH  high while the channel is in RUN.
REQ-013 done  out  NUM_CH  one-cycle pulse on the clk edge where the channel reaches 00:00.
REQ-014 alarm  out  NUM_CH  high while the channel is in ALARM.
REQ-015 load_err  out  NUM_CH  one-cycle pulse when a load is rejected.

Function
REQ-016 One shared prescaler shall count 0..TICK_DIV-1 and emit a one-cycle tick when it wraps; all channels shall decrement on the same tick.
REQ-017 Each channel shall run the FSM IDLE, LOADED, RUN, PAUSED, ALARM.
REQ-018 IDLE/LOADED + valid load_en -> LOADED with time_out = load_time on the next cycle.
REQ-019 Loads shall be valid only with m_ones<=9, s_tens<=5, s_ones<=9; any other value gives a load_err pulse with state and time unchanged.
REQ-020 LOADED + start with non-zero time -> RUN; start with 00:00 shall be ignored.
REQ-021 RUN + tick: decrement one second with BCD borrow (s_ones 0->9, s_tens 0->5, m_ones 0->9, m_tens -1); at 01:00 the next value is 00:59.
REQ-022 RUN + tick while time is 00:01 -> time 00:00, done pulse, ALARM on the same edge.
REQ-023 RUN + pause -> PAUSED with time frozen; PAUSED + start -> RUN; ticks in PAUSED shall not decrement.
REQ-024 ALARM shall last ALARM_SEC ticks, then go to IDLE with time 00:00.
REQ-025 clear shall move any state to IDLE with time 00:00 on the next edge.
REQ-026 Per-channel priority on the same cycle: clear > load_en > pause > start; load_en shall be ignored in RUN, PAUSED and ALARM.
REQ-027 A pause coinciding with the terminal tick shall yield ALARM (done pulse issued); a pause coinciding with a non-terminal tick shall store the decremented value.
REQ-028 Channels shall be fully independent apart from the shared tick.

Reset
REQ-029 reset shall drive all channels to IDLE, time_out all zero, running/done/alarm/load_err zero and the prescaler to 0, including mid-count.
REQ-030 After reset is released, the first tick shall occur TICK_DIV cycles later.

Configuration
REQ-031 Macro EGG_TIMER_AUTO_RELOAD_EN defined: at the terminal tick, a channel reloads its last valid loaded value, pulses done and stays in RUN (ALARM is never entered); undefined: behaviour per REQ-022/REQ-024.

Structure
REQ-032 Package egg_timer_pkg shall hold the state enum, the BCD time struct/width constant (14) and the digit limit constants (9, 5).
REQ-033 Sub-module egg_timer_channel (FSM plus BCD downcounter) shall be instantiated NUM_CH times by generate; the prescaler stays in the top level.

Verification (TICK_DIV=4, ALARM_SEC=2, NUM_CH=2)
REQ-034 Load ch0 with 44:42, start -> after 3 ticks time_out ch0 = 44:39, running[0]=1.
REQ-035 Load 01:00, start, 1 tick -> 00:59; load 00:02, start, 2 ticks -> 00:00, done one cycle, alarm for 2 ticks, then IDLE.
REQ-036 Load 06:70 -> load_err pulse, state and time unchanged; start with 00:00 -> still not running.
REQ-037 ch0 RUN, pause for 5 ticks, then start -> time unchanged across the pause, resumes decrementing; ch1 unaffected throughout.
REQ-038 Same cycle clear+start on ch1 -> IDLE at 00:00; reset asserted mid-RUN -> all outputs zero on the next edge.
REQ-039 With EGG_TIMER_AUTO_RELOAD_EN, load 00:02, start -> done pulse every 2 ticks, alarm stays 0, time cycles 00:02 -> 00:01 -> 00:02.
